btb_predictor: RTL and testbench

Direct-mapped branch target buffer with 2-bit saturating direction counters, sitting in the fetch stage directly upstream of the program counter. Each cycle it looks up the fetch PC combinationally and supplies `btb_hit`/`btb_nxt_pc` so the PC can redirect in the same cycle. It pipelines the hit flag down to EX as `btb_hit_ID_EX`, where the PC uses it to recover from mispredictions. It is trained by resolved branches and jumps from the EX stage.

---
 rtl/btb_pkg.sv | 21 ++
 rtl/btb_sat_ctr2.sv | 20 ++
 rtl/btb_predictor.sv | 106 ++++++++++
 tb/tb_btb_predictor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer: counter encoding,
// default geometry and the table entry layout.
package btb_pkg;

  localparam int BTB_IDX_W = 4;
  localparam int BTB_TAG_W = 16 - BTB_IDX_W;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  // Entry geometry follows BTB_IDX_W; change it here rather than overriding IDX_W alone.
  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [15:0]          target;
    logic [1:0]           ctr;
  } btb_entry_t;

endpackage

// File: rtl/btb_sat_ctr2.sv
// Combinational next state of a 2-bit saturating direction counter.
module btb_sat_ctr2
  import btb_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  // NOTE: default assigned first so no path through always_comb leaves ctr_next unassigned (no latch).
  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: combinational fetch lookup,
// EX-stage training, hit flag piped to EX. Optional stats via `BTB_STATS_EN`.
module btb_predictor
  import btb_pkg::*;
#(
  parameter int IDX_W = BTB_IDX_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc,
  input  logic        stall_IM_ID,
  input  logic        flow_change_ID_EX,
  input  logic        upd_valid,
  input  logic [15:0] upd_pc,
  input  logic        upd_taken,
  input  logic [15:0] upd_target,
  output logic        btb_hit,
  output logic [15:0] btb_nxt_pc,
  output logic        btb_hit_ID_EX
`ifdef BTB_STATS_EN
  ,
  output logic [15:0] stat_lookups,
  output logic [15:0] stat_hits
`endif
);

  localparam int DEPTH = 2 ** IDX_W;

  btb_entry_t       table_q [DEPTH];
  btb_entry_t       rd_entry;
  btb_entry_t       wr_entry;
  btb_entry_t       wr_data;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_match;
  logic             wr_en;
  logic [1:0]       ctr_next;
  logic             hit_IM_ID;

  // Fetch-side lookup; reads the pre-update contents when the same index is being trained.
  assign rd_idx     = pc[IDX_W-1:0];
  assign rd_entry   = table_q[rd_idx];
  assign btb_hit    = rd_entry.valid && (rd_entry.tag == pc[15:IDX_W]) && rd_entry.ctr[1];
  assign btb_nxt_pc = btb_hit ? rd_entry.target : 16'h0000;

  assign wr_idx   = upd_pc[IDX_W-1:0];
  assign wr_entry = table_q[wr_idx];
  assign wr_match = wr_entry.valid && (wr_entry.tag == upd_pc[15:IDX_W]);

  btb_sat_ctr2 u_sat_ctr (
    .ctr      (wr_entry.ctr),
    .taken    (upd_taken),
    .ctr_next (ctr_next)
  );

  always_comb begin
    wr_en   = 1'b0;
    wr_data = wr_entry;
    if (upd_valid) begin
      if (wr_match) begin
        wr_en        = 1'b1;
        wr_data.ctr  = ctr_next;
        if (upd_taken) wr_data.target = upd_target;
      end else if (upd_taken) begin
        wr_en   = 1'b1;
        wr_data = '{valid: 1'b1, tag: upd_pc[15:IDX_W], target: upd_target, ctr: CTR_WT};
      end
    end
  end

  // NOTE: the table is flops, not RAM, precisely so that every entry can be cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, target: 16'h0000, ctr: CTR_WNT};
      end
    end else if (wr_en) begin
      table_q[wr_idx] <= wr_data;
    end
  end

  // NOTE: non-blocking assignments so btb_hit_ID_EX takes the old hit_IM_ID, giving two stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_IM_ID     <= 1'b0;
      btb_hit_ID_EX <= 1'b0;
    end else begin
      btb_hit_ID_EX <= hit_IM_ID;
      if (flow_change_ID_EX) hit_IM_ID <= 1'b0;
      else if (!stall_IM_ID) hit_IM_ID <= btb_hit;
    end
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lookups <= 16'h0000;
      stat_hits    <= 16'h0000;
    end else if (!stall_IM_ID) begin
      if (stat_lookups != 16'hFFFF) stat_lookups <= stat_lookups + 16'd1;
      if (btb_hit && (stat_hits != 16'hFFFF)) stat_hits <= stat_hits + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Self-checking bench for btb_predictor: directed table, stall/flush and reset
// sequences, then random traffic against a behavioural model.
module tb_btb_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc;
  logic        stall_IM_ID;
  logic        flow_change_ID_EX;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic        upd_taken;
  logic [15:0] upd_target;
  logic        btb_hit;
  logic [15:0] btb_nxt_pc;
  logic        btb_hit_ID_EX;
`ifdef BTB_STATS_EN
  logic [15:0] stat_lookups;
  logic [15:0] stat_hits;
`endif

  btb_predictor #(.IDX_W(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc                (pc),
    .stall_IM_ID       (stall_IM_ID),
    .flow_change_ID_EX (flow_change_ID_EX),
    .upd_valid         (upd_valid),
    .upd_pc            (upd_pc),
    .upd_taken         (upd_taken),
    .upd_target        (upd_target),
    .btb_hit           (btb_hit),
    .btb_nxt_pc        (btb_nxt_pc),
    .btb_hit_ID_EX     (btb_hit_ID_EX)
`ifdef BTB_STATS_EN
    ,
    .stat_lookups      (stat_lookups),
    .stat_hits         (stat_hits)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: table kept as plain arrays, counters as integers 0..3.
  bit          m_valid [16];
  logic [11:0] m_tag   [16];
  logic [15:0] m_tgt   [16];
  int          m_ctr   [16];
  bit          m_im_id, m_id_ex;
  int          m_lookups, m_hits;

  function automatic bit m_hit(input logic [15:0] a);
    return m_valid[a[3:0]] && (m_tag[a[3:0]] == a[15:4]) && (m_ctr[a[3:0]] >= 2);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_im_id = 0; m_id_ex = 0; m_lookups = 0; m_hits = 0;
  endfunction

  function automatic void m_edge(input bit eh);
    int i;
    m_id_ex = m_im_id;
    if (flow_change_ID_EX) m_im_id = 0;
    else if (!stall_IM_ID) m_im_id = eh;
    if (!stall_IM_ID) begin
      if (m_lookups < 65535) m_lookups++;
      if (eh && m_hits < 65535) m_hits++;
    end
    if (upd_valid) begin
      i = int'(upd_pc[3:0]);
      if (m_valid[i] && m_tag[i] == upd_pc[15:4]) begin
        if (upd_taken) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = upd_target;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (upd_taken) begin
        m_valid[i] = 1; m_tag[i] = upd_pc[15:4]; m_tgt[i] = upd_target; m_ctr[i] = 2;
      end
    end
  endfunction

  logic        s_hit;
  logic [15:0] s_nxt;

  // One clock: sample combinational outputs mid-cycle, then the registered one after the edge.
  task automatic step();
    bit          eh;
    logic [15:0] et;
    @(negedge clk);
    eh = m_hit(pc);
    et = eh ? m_tgt[pc[3:0]] : 16'h0000;
    s_hit = btb_hit;
    s_nxt = btb_nxt_pc;
    check("btb_hit", {31'd0, btb_hit}, {31'd0, eh});
    check("btb_nxt_pc", {16'd0, btb_nxt_pc}, {16'd0, et});
    @(posedge clk);
    m_edge(eh);
    #1;
    check("btb_hit_ID_EX", {31'd0, btb_hit_ID_EX}, {31'd0, m_id_ex});
  endtask

  task automatic drive(input logic [15:0] a, input logic st, input logic fl,
                       input logic uv, input logic [15:0] upc, input logic ut,
                       input logic [15:0] utgt);
    pc = a; stall_IM_ID = st; flow_change_ID_EX = fl;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
  endtask

  task automatic do_reset();
    drive(16'h0005, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] pc;
    logic        uv;
    logic [15:0] upc;
    logic        ut;
    logic [15:0] utgt;
    logic        eh;
    logic [15:0] enxt;
  } vec_t;

  vec_t vecs [15];

  initial begin
    vecs[0]  = '{16'h0005, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[1]  = '{16'h0005, 1'b1, 16'h0005, 1'b1, 16'h0040, 1'b0, 16'h0000};
    vecs[2]  = '{16'h0005, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0040};
    vecs[3]  = '{16'h0005, 1'b1, 16'h0005, 1'b0, 16'h0000, 1'b1, 16'h0040};
    vecs[4]  = '{16'h0005, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[5]  = '{16'h0005, 1'b1, 16'h0005, 1'b1, 16'h0040, 1'b0, 16'h0000};
    vecs[6]  = '{16'h0005, 1'b1, 16'h0005, 1'b1, 16'h0040, 1'b1, 16'h0040};
    vecs[7]  = '{16'h0005, 1'b1, 16'h0005, 1'b0, 16'h0000, 1'b1, 16'h0040};
    vecs[8]  = '{16'h0005, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0040};
    vecs[9]  = '{16'h0015, 1'b1, 16'h0015, 1'b1, 16'h0080, 1'b0, 16'h0000};
    vecs[10] = '{16'h0005, 1'b1, 16'h0025, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[11] = '{16'h0015, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0080};
    vecs[12] = '{16'h0025, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[13] = '{16'h0015, 1'b1, 16'h0015, 1'b1, 16'h0090, 1'b1, 16'h0080};
    vecs[14] = '{16'h0015, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0090};

    do_reset();
    check("reset_hit", {31'd0, btb_hit}, 32'd0);
    check("reset_nxt_pc", {16'd0, btb_nxt_pc}, 32'd0);
    check("reset_hit_ID_EX", {31'd0, btb_hit_ID_EX}, 32'd0);

    // Training, counter hysteresis, aliasing and target refresh.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].pc, 1'b0, 1'b0, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utgt);
      step();
      check($sformatf("vec%0d_hit", i), {31'd0, s_hit}, {31'd0, vecs[i].eh});
      check($sformatf("vec%0d_nxt", i), {16'd0, s_nxt}, {16'd0, vecs[i].enxt});
      if (i == 3) check("hit_ID_EX_two_cycles_after_hit", {31'd0, btb_hit_ID_EX}, 32'd1);
    end

    // Stall holds the captured hit; a flush during the stall clears it.
    drive(16'h0015, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(16'h0025, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
      step();
      check($sformatf("stall%0d_hit_ID_EX", i), {31'd0, btb_hit_ID_EX}, 32'd1);
    end
    drive(16'h0025, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    check("flush_edge_hit_ID_EX", {31'd0, btb_hit_ID_EX}, 32'd1);
    drive(16'h0025, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    step();
    check("after_flush_hit_ID_EX", {31'd0, btb_hit_ID_EX}, 32'd0);

    // Reset asserted while an update is pending: the update is lost, table cleared at once.
    drive(16'h0015, 1'b0, 1'b0, 1'b1, 16'h0007, 1'b1, 16'h0100);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check("async_reset_hit", {31'd0, btb_hit}, 32'd0);
    check("async_reset_nxt", {16'd0, btb_nxt_pc}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    drive(16'h0007, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    rst_n = 1'b1;
    step();
    check("lost_update_miss", {31'd0, s_hit}, 32'd0);

    // Random traffic on a small address set so aliasing and retraining are frequent.
    for (int n = 0; n < 600; n++) begin
      drive(16'((($urandom_range(0, 3)) << 4) | $urandom_range(0, 3)),
            1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 1)),
            16'((($urandom_range(0, 3)) << 4) | $urandom_range(0, 3)),
            1'($urandom_range(0, 9) < 7), 16'($urandom));
      step();
    end
`ifdef BTB_STATS_EN
    check("rand_stat_lookups", {16'd0, stat_lookups}, 32'(m_lookups));
    check("rand_stat_hits", {16'd0, stat_hits}, 32'(m_hits));

    do_reset();
    check("reset_stat_lookups", {16'd0, stat_lookups}, 32'd0);
    drive(16'h0025, 1'b1, 1'b0, 1'b1, 16'h0015, 1'b1, 16'h0aa0);
    step();
    for (int i = 0; i < 10; i++) begin
      drive((i % 3 == 0) ? 16'h0015 : 16'h0025, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
      step();
    end
    check("ten_cycles_lookups", {16'd0, stat_lookups}, 32'd10);
    check("ten_cycles_hits", {16'd0, stat_hits}, 32'd4);
    drive(16'h0015, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    repeat (65540) @(posedge clk);
    #1;
    check("sat_lookups", {16'd0, stat_lookups}, 32'h0000FFFF);
    check("sat_hits", {16'd0, stat_hits}, 32'h0000FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
